// File: rtl/vote_session_ctrl.sv
// Poll-session controller: one vote per authorization, press arbitration,
// post-vote lockout and poll open/close sequencing for the voting machine.
module vote_session_ctrl #(
    parameter int unsigned LOCKOUT_CYCLES = 10,
    parameter int unsigned ARM_TIMEOUT    = 1000,
    parameter int unsigned MAX_BALLOTS    = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       open_poll,
    input  logic       close_poll,
    input  logic       authorize,
    input  logic [3:0] valid_vote,
    output logic [3:0] vote_grant,
    output logic       armed,
    output logic       vote_ack,
    output logic       poll_open,
    output logic       results_mode,
    output logic [7:0] ballot_count,
    output logic [7:0] spoiled_count
);

    localparam int unsigned TMAX = (ARM_TIMEOUT > LOCKOUT_CYCLES) ? ARM_TIMEOUT : LOCKOUT_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam logic [7:0]  MAX_B = 8'(MAX_BALLOTS);

    typedef enum logic [2:0] {
        ST_CLOSED,
        ST_IDLE,
        ST_ARMED,
        ST_GRANT,
        ST_LOCKOUT
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [TW-1:0] timer;
    logic          close_pending;
    logic          one_press;
    logic          multi_press;

    always_comb begin
        one_press   = ($countones(valid_vote) == 1);
        multi_press = ($countones(valid_vote) > 1);
        next_state  = state;
        case (state)
            ST_CLOSED:  if (open_poll && (ballot_count < MAX_B)) next_state = ST_IDLE;
            ST_IDLE: begin
                if (close_poll)     next_state = ST_CLOSED;
                else if (authorize) next_state = ST_ARMED;
            end
            // A press outranks close and timeout; a close arriving with it is held pending.
            ST_ARMED: begin
                if (one_press)         next_state = ST_GRANT;
                else if (multi_press)  next_state = ST_LOCKOUT;
                else if (close_poll)   next_state = ST_CLOSED;
                else if (timer == '0)  next_state = ST_IDLE;
            end
            ST_GRANT:   next_state = ST_LOCKOUT;
            ST_LOCKOUT: begin
                if (timer == '0) begin
                    if (close_pending || close_poll || (ballot_count == MAX_B))
                        next_state = ST_CLOSED;
                    else
                        next_state = ST_IDLE;
                end
            end
            default:    next_state = ST_CLOSED;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_CLOSED;
        else        state <= next_state;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer         <= '0;
            close_pending <= 1'b0;
            ballot_count  <= '0;
            spoiled_count <= '0;
            vote_grant    <= '0;
            armed         <= 1'b0;
            vote_ack      <= 1'b0;
            poll_open     <= 1'b0;
            results_mode  <= 1'b1;
        end else begin
            // Timer reloads on state entry so it reads zero on the final cycle of the dwell.
            if (next_state == ST_ARMED && state != ST_ARMED)
                timer <= TW'(ARM_TIMEOUT - 1);
            else if (next_state == ST_LOCKOUT && state != ST_LOCKOUT)
                timer <= TW'(LOCKOUT_CYCLES - 1);
            else if (timer != '0)
                timer <= timer - TW'(1);

            if (next_state == ST_CLOSED)
                close_pending <= 1'b0;
            else if (close_poll && (state == ST_GRANT || state == ST_LOCKOUT ||
                     (state == ST_ARMED && (one_press || multi_press))))
                close_pending <= 1'b1;

            if (state == ST_GRANT && ballot_count < MAX_B)
                ballot_count <= ballot_count + 8'd1;
            if (state == ST_ARMED && multi_press && spoiled_count != '1)
                spoiled_count <= spoiled_count + 8'd1;

            vote_grant   <= (next_state == ST_GRANT) ? valid_vote : '0;
            armed        <= (next_state == ST_ARMED);
            vote_ack     <= (next_state == ST_LOCKOUT);
            poll_open    <= (next_state != ST_CLOSED);
            results_mode <= (next_state == ST_CLOSED);
        end
    end

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Directed bench for vote_session_ctrl: grant, spoil, ignored inputs, timeout,
// close handling, ballot cap and asynchronous reset.
module tb_vote_session_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       open_poll;
    logic       close_poll;
    logic       authorize;
    logic [3:0] valid_vote;
    logic [3:0] vote_grant;
    logic       armed;
    logic       vote_ack;
    logic       poll_open;
    logic       results_mode;
    logic [7:0] ballot_count;
    logic [7:0] spoiled_count;

    int checks   = 0;
    int errors   = 0;
    int timeouts = 0;
    int n;
    logic [3:0] grant_seen;

    vote_session_ctrl #(
        .LOCKOUT_CYCLES(10),
        .ARM_TIMEOUT   (1000),
        .MAX_BALLOTS   (255)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .open_poll    (open_poll),
        .close_poll   (close_poll),
        .authorize    (authorize),
        .valid_vote   (valid_vote),
        .vote_grant   (vote_grant),
        .armed        (armed),
        .vote_ack     (vote_ack),
        .poll_open    (poll_open),
        .results_mode (results_mode),
        .ballot_count (ballot_count),
        .spoiled_count(spoiled_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Counts samples with vote_ack high, starting at the current sample.
    task automatic wait_ack_low(output int cnt);
        cnt = 0;
        while (vote_ack && cnt < 50) begin
            cnt++;
            tick();
        end
        if (cnt >= 50) timeouts++;
    endtask

    task automatic do_grant(input logic [3:0] vv);
        int c;
        authorize = 1'b1; tick(); authorize = 1'b0;
        valid_vote = vv;  tick(); valid_vote = '0;
        tick();
        wait_ack_low(c);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"},   32'(vote_grant), 0);
        check({tag, "_armed"},   32'(armed), 0);
        check({tag, "_ack"},     32'(vote_ack), 0);
        check({tag, "_open"},    32'(poll_open), 0);
        check({tag, "_results"}, 32'(results_mode), 1);
        check({tag, "_ballots"}, 32'(ballot_count), 0);
        check({tag, "_spoiled"}, 32'(spoiled_count), 0);
    endtask

    initial begin
        reset = 1'b0; open_poll = 1'b0; close_poll = 1'b0;
        authorize = 1'b0; valid_vote = '0;
        tick(); tick();
        check_reset_outputs("rst");
        reset = 1'b1;
        tick();

        // open
        open_poll = 1'b1; tick(); open_poll = 1'b0;
        check("open_poll_open", 32'(poll_open), 1);
        check("open_results", 32'(results_mode), 0);

        // single press of candidate 3
        authorize = 1'b1; tick(); authorize = 1'b0;
        check("arm_armed", 32'(armed), 1);
        valid_vote = 4'b0100; tick(); valid_vote = '0;
        check("g1_grant", 32'(vote_grant), 32'h4);
        check("g1_armed", 32'(armed), 0);
        check("g1_ack_early", 32'(vote_ack), 0);
        check("g1_ballot_early", 32'(ballot_count), 0);
        tick();
        check("g1_grant_off", 32'(vote_grant), 0);
        check("g1_ballot", 32'(ballot_count), 1);
        wait_ack_low(n);
        check("g1_ack_len", 32'(n), 10);
        check("g1_idle_open", 32'(poll_open), 1);
        check("g1_idle_armed", 32'(armed), 0);

        // spoil: candidates 1 and 2 together
        authorize = 1'b1; tick(); authorize = 1'b0;
        valid_vote = 4'b0011; tick(); valid_vote = '0;
        check("sp_ack", 32'(vote_ack), 1);
        check("sp_spoiled", 32'(spoiled_count), 1);
        grant_seen = vote_grant;
        n = 0;
        while (vote_ack && n < 50) begin
            grant_seen |= vote_grant;
            n++;
            tick();
        end
        if (n >= 50) timeouts++;
        check("sp_ack_len", 32'(n), 10);
        check("sp_no_grant", 32'(grant_seen), 0);
        check("sp_ballot", 32'(ballot_count), 1);

        // press with no authorize
        valid_vote = 4'b0001; tick(); valid_vote = '0;
        check("noauth_grant", 32'(vote_grant), 0);
        tick();
        check("noauth_ballot", 32'(ballot_count), 1);

        // authorize and press during lockout are ignored
        authorize = 1'b1; tick(); authorize = 1'b0;
        valid_vote = 4'b0001; tick(); valid_vote = '0;
        check("g2_grant", 32'(vote_grant), 32'h1);
        tick();
        authorize = 1'b1; tick(); authorize = 1'b0;
        check("lock_auth_armed", 32'(armed), 0);
        valid_vote = 4'b1000; tick(); valid_vote = '0;
        check("lock_press_grant", 32'(vote_grant), 0);
        wait_ack_low(n);
        check("lock_after_armed", 32'(armed), 0);
        check("lock_after_ballot", 32'(ballot_count), 2);
        tick();
        check("auth_not_queued", 32'(armed), 0);

        // arm timeout
        authorize = 1'b1; tick(); authorize = 1'b0;
        n = 0;
        while (armed && n < 1100) begin
            n++;
            tick();
        end
        if (n >= 1100) timeouts++;
        check("timeout_len", 32'(n), 1000);
        valid_vote = 4'b0010; tick(); valid_vote = '0;
        check("late_press_grant", 32'(vote_grant), 0);
        tick();
        check("late_press_ballot", 32'(ballot_count), 2);

        // close during lockout
        authorize = 1'b1; tick(); authorize = 1'b0;
        valid_vote = 4'b1000; tick(); valid_vote = '0;
        tick();
        close_poll = 1'b1; tick(); close_poll = 1'b0;
        check("cl_still_open", 32'(poll_open), 1);
        check("cl_still_ack", 32'(vote_ack), 1);
        wait_ack_low(n);
        check("cl_ack_rest", 32'(n), 9);
        check("cl_results", 32'(results_mode), 1);
        check("cl_open", 32'(poll_open), 0);
        check("cl_ballot", 32'(ballot_count), 3);
        open_poll = 1'b1; tick(); open_poll = 1'b0;
        check("reopen_open", 32'(poll_open), 1);
        check("reopen_ballot", 32'(ballot_count), 3);
        check("reopen_spoiled", 32'(spoiled_count), 1);

        // close and authorize together in IDLE: close wins
        close_poll = 1'b1; authorize = 1'b1; tick();
        close_poll = 1'b0; authorize = 1'b0;
        check("closeauth_armed", 32'(armed), 0);
        check("closeauth_results", 32'(results_mode), 1);
        open_poll = 1'b1; tick(); open_poll = 1'b0;

        // run to the ballot cap
        for (int i = 0; i < 252; i++) begin
            logic [3:0] cand;
            cand = 4'b0001 << (i % 4);
            do_grant(cand);
        end
        check("cap_ballot", 32'(ballot_count), 255);
        check("cap_results", 32'(results_mode), 1);
        open_poll = 1'b1; tick(); open_poll = 1'b0;
        tick();
        check("cap_reopen_open", 32'(poll_open), 0);
        check("cap_reopen_ballot", 32'(ballot_count), 255);

        // async reset mid-GRANT
        #2 reset = 1'b0; #1;
        check_reset_outputs("rst_cap");
        tick(); reset = 1'b1; tick();
        open_poll = 1'b1; tick(); open_poll = 1'b0;
        authorize = 1'b1; tick(); authorize = 1'b0;
        valid_vote = 4'b0010; tick(); valid_vote = '0;
        check("mg_grant_pre", 32'(vote_grant), 32'h2);
        #2 reset = 1'b0; #1;
        check_reset_outputs("rst_grant");
        tick(); reset = 1'b1; tick();

        // async reset mid-LOCKOUT
        open_poll = 1'b1; tick(); open_poll = 1'b0;
        authorize = 1'b1; tick(); authorize = 1'b0;
        valid_vote = 4'b0100; tick(); valid_vote = '0;
        tick(); tick();
        check("ml_ack_pre", 32'(vote_ack), 1);
        #2 reset = 1'b0; #1;
        check_reset_outputs("rst_lock");
        tick(); reset = 1'b1; tick();

        check("wait_bounds", 32'(timeouts), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
